base_aburp_rrarb: RTL and testbench

BASE_ABURP_RRARB -- requirements
Module: base_aburp_rrarb

---
 rtl/base_aburp_rrarb.sv | 158 +++++++++++++++
 tb/tb_base_aburp_rrarb.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/base_aburp_rrarb.sv
// ============================================================================
// Module   : base_aburp_rrarb
// Brief    : Packet-locking round-robin arbiter with a registered output
//            stage and a one-beat burp buffer; all ready paths are registered.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module base_aburp_rrarb #(
    parameter int WIDTH = 1,
    parameter int WAYS  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [0:WAYS-1]         i_v,
    output logic [0:WAYS-1]         i_r,
    input  logic [0:WAYS*WIDTH-1]   i_d,
    input  logic [0:WAYS-1]         i_last,
    output logic                    o_v,
    input  logic                    o_r,
    output logic [0:WIDTH-1]        o_d,
    output logic [0:WAYS-1]         o_sel,
    output logic                    o_last
);

    localparam int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   w_ptr_nxt;
    logic [PTR_W-1:0]   r_owner;
    logic [PTR_W-1:0]   w_owner_nxt;
    logic [PTR_W-1:0]   w_gidx;
    logic               w_gfound;
    logic [0:WAYS-1]    w_grant;

    logic               r_o_v;
    logic [0:WIDTH-1]   r_o_d;
    logic [0:WAYS-1]    r_o_sel;
    logic               r_o_last;

    logic               r_burp_v;
    logic [0:WIDTH-1]   r_burp_d;
    logic [0:WAYS-1]    r_burp_sel;
    logic               r_burp_last;

    logic               w_s_r;
    logic               w_acc;
    logic               w_load;
    logic [0:WIDTH-1]   w_acc_d;
    logic               w_acc_last;

    // Stage ready depends only on registered state, never on o_r.
    assign w_s_r  = ~r_burp_v;
    assign w_acc  = w_gfound & w_s_r & ~reset;
    assign w_load = ~r_o_v | o_r;
    assign i_r    = w_grant & {WAYS{w_s_r & ~reset}};

    assign w_acc_d    = i_d[int'(w_gidx)*WIDTH +: WIDTH];
    assign w_acc_last = i_last[w_gidx];

    always_comb begin : p_grant
        int idx;
        idx      = 0;
        w_gfound = 1'b0;
        w_gidx   = '0;
        w_grant  = '0;
        if (r_state == ST_LOCKED) begin
            w_gfound = i_v[r_owner];
            w_gidx   = r_owner;
        end else begin
            for (int j = 0; j < WAYS; j++) begin
                idx = int'(r_ptr) + j;
                if (idx >= WAYS) idx = idx - WAYS;
                if (!w_gfound && i_v[idx]) begin
                    w_gfound = 1'b1;
                    w_gidx   = PTR_W'(idx);
                end
            end
        end
        if (w_gfound) w_grant[w_gidx] = 1'b1;
    end

    always_comb begin : p_next
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        if (w_acc) begin
            if (w_acc_last) begin
                w_state_nxt = ST_IDLE;
                w_ptr_nxt   = (int'(w_gidx) == WAYS - 1) ? '0 : w_gidx + PTR_W'(1);
            end else begin
                w_state_nxt = ST_LOCKED;
                w_owner_nxt = w_gidx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    // Burp buffer absorbs the one beat accepted while the output is stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_o_v       <= 1'b0;
            r_o_d       <= '0;
            r_o_sel     <= '0;
            r_o_last    <= 1'b0;
            r_burp_v    <= 1'b0;
            r_burp_d    <= '0;
            r_burp_sel  <= '0;
            r_burp_last <= 1'b0;
        end else if (w_load) begin
            if (r_burp_v) begin
                r_o_v    <= 1'b1;
                r_o_d    <= r_burp_d;
                r_o_sel  <= r_burp_sel;
                r_o_last <= r_burp_last;
                r_burp_v <= 1'b0;
            end else if (w_acc) begin
                r_o_v    <= 1'b1;
                r_o_d    <= w_acc_d;
                r_o_sel  <= w_grant;
                r_o_last <= w_acc_last;
            end else begin
                r_o_v    <= 1'b0;
            end
        end else if (w_acc) begin
            r_burp_v    <= 1'b1;
            r_burp_d    <= w_acc_d;
            r_burp_sel  <= w_grant;
            r_burp_last <= w_acc_last;
        end
    end

    assign o_v    = r_o_v;
    assign o_d    = r_o_d;
    assign o_sel  = r_o_sel;
    assign o_last = r_o_last;

endmodule

`default_nettype wire

// File: tb/tb_base_aburp_rrarb.sv
// ============================================================================
// Module   : tb_base_aburp_rrarb
// Brief    : Self-checking bench for base_aburp_rrarb (WAYS=4, WIDTH=8) with
//            a cycle model and an in-order beat scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_base_aburp_rrarb;

    localparam int WAYS  = 4;
    localparam int WIDTH = 8;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [0:WAYS-1]        i_v;
    logic [0:WAYS-1]        i_r;
    logic [0:WAYS*WIDTH-1]  i_d;
    logic [0:WAYS-1]        i_last;
    logic                   o_v;
    logic                   o_r;
    logic [0:WIDTH-1]       o_d;
    logic [0:WAYS-1]        o_sel;
    logic                   o_last;

    base_aburp_rrarb #(.WIDTH(WIDTH), .WAYS(WAYS)) dut (
        .clk    (clk),
        .reset  (reset),
        .i_v    (i_v),
        .i_r    (i_r),
        .i_d    (i_d),
        .i_last (i_last),
        .o_v    (o_v),
        .o_r    (o_r),
        .o_d    (o_d),
        .o_sel  (o_sel),
        .o_last (o_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [0:3] sel;
        logic [7:0] d;
        logic       last;
    } beat_t;

    beat_t      m_q[$];
    int         m_ptr, m_owner, max_wait;
    logic       m_locked, m_burp, m_ov;
    int         w_cnt[WAYS];
    int         n_chk = 0;
    int         n_err = 0;
    logic [0:3] last_ir, last_sel;
    logic [7:0] last_d;
    logic [0:3] sel_log[6];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [0:3] onehot(input int k);
        logic [0:3] r;
        r = '0;
        r[k] = 1'b1;
        return r;
    endfunction

    function automatic int m_pick(input logic [0:3] v);
        int idx;
        if (m_locked) return v[m_owner] ? m_owner : -1;
        for (int j = 0; j < WAYS; j++) begin
            idx = (m_ptr + j) % WAYS;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        i_v   = '1;
        o_r   = 1'b1;
        #1;
        check("rst_ir", i_r, 0);
        @(posedge clk);
        #1;
        check("rst_ov", o_v, 0);
        check("rst_sel", o_sel, 0);
        check("rst_d", o_d, 0);
        check("rst_last", o_last, 0);
        reset = 1'b0;
        m_q.delete();
        m_ptr = 0; m_owner = 0; m_locked = 0; m_burp = 0; m_ov = 0;
        for (int k = 0; k < WAYS; k++) w_cnt[k] = 0;
    endtask

    task automatic step(input logic [0:3] v, input logic [0:3] last,
                        input logic [7:0] db, input logic ordy);
        int         g;
        logic [0:3] exp_ir;
        logic       acc, load;
        beat_t      b;
        @(negedge clk);
        i_v = v; i_last = last; o_r = ordy;
        for (int k = 0; k < WAYS; k++) i_d[k*WIDTH +: WIDTH] = db + 8'(k);
        #1;
        g = m_pick(v);
        exp_ir = (g >= 0 && !m_burp) ? onehot(g) : 4'b0000;
        last_ir = i_r; last_sel = o_sel; last_d = o_d;
        check("i_r", i_r, exp_ir);
        check("o_v", o_v, m_ov);
        if (m_ov && m_q.size() > 0) begin
            b = m_q[0];
            check("o_d", o_d, b.d);
            check("o_sel", o_sel, b.sel);
            check("o_last", o_last, b.last);
            check("sel_onehot", $onehot(o_sel), 1);
        end
        acc  = (exp_ir != 4'b0000);
        load = !m_ov || ordy;
        if (m_ov && ordy && m_q.size() > 0) void'(m_q.pop_front());
        for (int k = 0; k < WAYS; k++) begin
            if (!v[k]) w_cnt[k] = 0;
            else if (acc && g == k) w_cnt[k] = 0;
            else if (acc && last[g]) begin
                w_cnt[k]++;
                if (w_cnt[k] > max_wait) max_wait = w_cnt[k];
            end
        end
        if (acc) begin
            b.sel = onehot(g); b.d = db + 8'(g); b.last = last[g];
            m_q.push_back(b);
            if (last[g]) begin m_locked = 0; m_ptr = (g + 1) % WAYS; end
            else begin m_locked = 1; m_owner = g; end
        end
        if (load) begin m_ov = m_burp || acc; m_burp = 0; end
        else if (acc) m_burp = 1;
    endtask

    initial begin
        logic [0:3] rv, rl;
        reset = 1'b1; i_v = '0; i_last = '0; i_d = '0; o_r = 1'b0;
        max_wait = 0;
        do_reset();

        // All requesters streaming single-beat packets: strict rotation.
        for (int s = 0; s < 6; s++) begin
            step(4'b1111, 4'b1111, 8'(16*s), 1'b1);
            sel_log[s] = last_sel;
        end
        check("rr_sel1", sel_log[1], 4'b1000);
        check("rr_sel2", sel_log[2], 4'b0100);
        check("rr_sel3", sel_log[3], 4'b0010);
        check("rr_sel4", sel_log[4], 4'b0001);
        check("rr_sel5", sel_log[5], 4'b1000);

        // Three-beat packet from requester 0 holds off requester 1.
        do_reset();
        step(4'b1100, 4'b0000, 8'h10, 1'b1); check("lk_ir1", last_ir, 4'b1000);
        step(4'b1100, 4'b0000, 8'h20, 1'b1); check("lk_ir2", last_ir, 4'b1000);
        check("lk_sel1", last_sel, 4'b1000);
        step(4'b1100, 4'b1000, 8'h30, 1'b1); check("lk_ir3", last_ir, 4'b1000);
        check("lk_sel2", last_sel, 4'b1000);
        step(4'b1100, 4'b1111, 8'h40, 1'b1); check("lk_ir4", last_ir, 4'b0100);
        check("lk_sel3", last_sel, 4'b1000);
        step(4'b1100, 4'b1111, 8'h50, 1'b1);
        check("lk_sel4", last_sel, 4'b0100);

        // Burp: beat 0x05 taken while output stalled, drained after o_r.
        do_reset();
        step(4'b1000, 4'b1000, 8'h33, 1'b0);
        step(4'b1000, 4'b1000, 8'h05, 1'b0); check("bp_ir0", last_ir, 4'b1000);
        step(4'b1000, 4'b1000, 8'h77, 1'b0); check("bp_ir1", last_ir, 4'b0000);
        check("bp_d0", last_d, 8'h33);
        step(4'b1000, 4'b1000, 8'h77, 1'b1); check("bp_ir2", last_ir, 4'b0000);
        step(4'b1000, 4'b1000, 8'h77, 1'b1); check("bp_d1", last_d, 8'h05);
        check("bp_ir3", last_ir, 4'b1000);

        // Reset mid-packet with full pipeline, owner 2.
        do_reset();
        step(4'b0010, 4'b0000, 8'h60, 1'b0); check("mr_ir0", last_ir, 4'b0010);
        step(4'b0010, 4'b0000, 8'h61, 1'b0);
        step(4'b0010, 4'b0000, 8'h62, 1'b0); check("mr_ir1", last_ir, 4'b0000);
        do_reset();
        step(4'b1111, 4'b1111, 8'h70, 1'b1); check("mr_ir2", last_ir, 4'b1000);

        // Random traffic against the model and scoreboard.
        max_wait = 0;
        for (int c = 0; c < 6000; c++) begin
            for (int k = 0; k < WAYS; k++) begin
                rv[k] = ($urandom_range(0, 9) < 7);
                rl[k] = ($urandom_range(0, 9) < 3);
            end
            step(rv, rl, 8'($urandom_range(0, 255)), ($urandom_range(0, 9) < 6));
            if (c == 3000) do_reset();
        end
        check("starve_bound", (max_wait <= WAYS - 1), 1);
        for (int c = 0; c < 6; c++) step(4'b0000, 4'b0000, 8'h00, 1'b1);
        check("drain_ov", o_v, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

`default_nettype wire
